// File: rtl/and_bitwise.sv
// Registered WIDTH-bit bitwise AND with valid strobe and zero flag, one-cycle latency.
// Optional enable port is compiled in when AND_BITWISE_ENABLE_EN is defined.
module and_bitwise #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic             i_valid,
`ifdef AND_BITWISE_ENABLE_EN
  input  logic             enable,
`endif
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic             o_zero
);

  logic             op_active;
  logic [WIDTH-1:0] and_res;

`ifdef AND_BITWISE_ENABLE_EN
  assign op_active = enable;
`else
  assign op_active = 1'b1;
`endif

  always_comb begin
    and_res = i_1 & i_2;
  end

  // A disabled unit presents the reset-like state so the result mux sees a clean zero.
  always_ff @(posedge clk) begin
    if (rst || !op_active) begin
      o       <= '0;
      o_valid <= 1'b0;
      o_zero  <= 1'b1;
    end else if (i_valid) begin
      o       <= and_res;
      o_valid <= 1'b1;
      o_zero  <= (and_res == '0);
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_and_bitwise.sv
// Scoreboard bench for and_bitwise: stimulus pushes expected per-cycle outputs,
// a monitor pops and compares one cycle later. Define AND_BITWISE_ENABLE_EN to exercise enable.
module tb_and_bitwise;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] o;
    logic             valid;
    logic             zero;
    string            tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] i_1;
  logic [WIDTH-1:0] i_2;
  logic             i_valid;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic             o_zero;
`ifdef AND_BITWISE_ENABLE_EN
  logic             enable;
`endif

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state: the last result the unit is expected to be holding.
  logic [WIDTH-1:0] ref_o    = '0;
  logic             ref_zero = 1'b1;

  and_bitwise #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_1     (i_1),
    .i_2     (i_2),
    .i_valid (i_valid),
`ifdef AND_BITWISE_ENABLE_EN
    .enable  (enable),
`endif
    .o       (o),
    .o_valid (o_valid),
    .o_zero  (o_zero)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, predict the outputs after the next rising edge.
  task automatic apply(input logic r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic v, input string tag);
    exp_t e;
    logic active;
    @(negedge clk);
    rst     = r;
    i_1     = a;
    i_2     = b;
    i_valid = v;
`ifdef AND_BITWISE_ENABLE_EN
    active = enable;
`else
    active = 1'b1;
`endif
    if (r || !active) begin
      ref_o    = '0;
      ref_zero = 1'b1;
      e.valid  = 1'b0;
    end else if (v) begin
      ref_o    = a & b;
      ref_zero = (ref_o == 0);
      e.valid  = 1'b1;
    end else begin
      e.valid  = 1'b0;
    end
    e.o    = ref_o;
    e.zero = ref_zero;
    e.tag  = tag;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compares every registered output cycle that has a pending prediction.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (o !== e.o || o_valid !== e.valid || o_zero !== e.zero) begin
        miscompares++;
        $display("FAIL %s: got o=%h o_valid=%b o_zero=%b, want o=%h o_valid=%b o_zero=%b",
                 e.tag, o, o_valid, o_zero, e.o, e.valid, e.zero);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    rst     = 1'b1;
    i_1     = '0;
    i_2     = '0;
    i_valid = 1'b0;
`ifdef AND_BITWISE_ENABLE_EN
    enable  = 1'b1;
`endif

    // Reset for two cycles with live operands that must be ignored
    apply(1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, "reset0");
    apply(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, "reset1");

    apply(1'b0, 32'h0000_129F, 32'h0000_0BD2, 1'b1, "basic");
    apply(1'b0, 32'hFFFF_FFFF, 32'hA849_2525, 1'b1, "b2b_first");
    apply(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "b2b_all_ones");
    apply(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "zero_result");
    for (int unsigned k = 0; k < 3; k++)
      apply(1'b0, 32'h5555_AAAA, 32'hFFFF_FFFF, 1'b0, "idle_hold");
    apply(1'b0, 32'h8000_0000, 32'h8000_0001, 1'b1, "msb_only");
    apply(1'b0, 32'h0000_0001, 32'h0000_0003, 1'b1, "lsb_only");
    apply(1'b0, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, "disjoint_bits");

`ifdef AND_BITWISE_ENABLE_EN
    enable = 1'b0;
    apply(1'b0, 32'hFF8F_E94B, 32'hFFFC_4A3F, 1'b1, "enable_off");
    enable = 1'b1;
    apply(1'b0, 32'hFF8F_E94B, 32'hFFFC_4A3F, 1'b1, "enable_on");
`endif

    apply(1'b0, 32'h1111_1111, 32'h3333_3333, 1'b1, "pre_reset");
    apply(1'b1, 32'hFFA5_21FF, 32'h8000_0007, 1'b1, "reset_with_valid");
    apply(1'b0, 32'hFFA5_21FF, 32'h8000_0007, 1'b1, "replay_after_reset");

    // Randomized traffic with biased operands and occasional reset
    for (int unsigned n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       a = '1;
        1:       a = '0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = '1;
        1:       b = ~a;
        default: b = $urandom;
      endcase
`ifdef AND_BITWISE_ENABLE_EN
      enable = ($urandom_range(0, 7) != 0);
`endif
      apply(($urandom_range(0, 31) == 0), a, b, ($urandom_range(0, 3) != 0), "random");
    end

    apply(1'b0, '0, '0, 1'b0, "drain");

    // Let the monitor consume the remaining predictions, bounded in cycles
    for (int unsigned w = 0; w < 10 && exp_q.size() > 0; w++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending predictions, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
